// File: rtl/simple_cpu_pkg.sv
// Shared types and helpers for the multi-cycle CPU: opcode and FSM enums,
// instruction field positions, and 8-bit immediate extension helpers.
// Pure declarations; no logic, no latency.
package simple_cpu_pkg;

  // Instruction opcodes; 8..E are undefined and trap as illegal.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_LDI  = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_BEQZ = 4'h6,
    OP_JMP  = 4'h7,
    OP_HALT = 4'hF
  } op_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Instruction field positions: [15:12] op, [11:8] rd, [7:4] rn, [3:0] rm.
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RN_LSB = 4;
  localparam int RM_LSB = 0;

  // Sign-extend an 8-bit immediate; callers size-cast to their width (<=32).
  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // Zero-extend an 8-bit immediate; callers size-cast to their width (<=32).
  function automatic logic [31:0] zext8(input logic [7:0] v);
    return {24'h0, v};
  endfunction

endpackage

// File: rtl/simple_regfile_p.sv
// Register file: NREGS x DATA_W, two combinational read ports, one write port.
// Reads are zero-latency, writes land at the clock edge.
// No backpressure; clear_n (synchronous, active-low) zeroes every register.
module simple_regfile_p #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [3:0]        ra_idx,
  output logic [DATA_W-1:0] ra_dat,
  input  logic [3:0]        rb_idx,
  output logic [DATA_W-1:0] rb_dat,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_dat
);

  // Only the low index bits are significant when fewer than 16 registers exist.
  localparam int IW = (NREGS > 2) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [IW-1:0]     ra_sel;
  logic [IW-1:0]     rb_sel;
  logic [IW-1:0]     wr_sel;

  assign ra_sel = ra_idx[IW-1:0];
  assign rb_sel = rb_idx[IW-1:0];
  assign wr_sel = wr_idx[IW-1:0];

  // Asynchronous reads; an index past NREGS (non power-of-two sizes) reads zero.
  assign ra_dat = (32'(ra_sel) < NREGS) ? regs[ra_sel] : '0;
  assign rb_dat = (32'(rb_sel) < NREGS) ? regs[rb_sel] : '0;

  // Synchronous clear has priority over the single write port.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (32'(wr_sel) < NREGS)) begin
      regs[wr_sel] <= wr_dat;
    end
  end

endmodule

// File: rtl/simple_cpu_mc.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC(/MEM) FSM with external I- and D-memory.
// Latency: 3 cycles per instruction, 3+N for LD/ST where ack arrives in the N-th MEM cycle.
// Data memory stalls the core via req/ack; req, we, addr and wdata are held until ack.
module simple_cpu_mc
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  state_e            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] opa;      // rn value captured in DECODE
  logic [DATA_W-1:0] opb;      // rm value, or rd value for ST/BEQZ
  op_e               op;
  op_e               dec_op;

  logic [DATA_W-1:0] ra_dat;
  logic [DATA_W-1:0] rb_dat;
  logic [3:0]        rb_idx;
  logic              wr_en;
  logic [DATA_W-1:0] wr_dat;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;
  logic [ADDR_W-1:0] mem_addr;

  assign imem_addr = pc;
  assign op        = op_e'(ir[OP_LSB +: 4]);
  assign dec_op    = op_e'(imem_rdata[OP_LSB +: 4]);

  // Port B reads rd instead of rm for the two opcodes that consume rd as a source.
  assign rb_idx = (dec_op == OP_ST || dec_op == OP_BEQZ) ? imem_rdata[RD_LSB +: 4]
                                                         : imem_rdata[RM_LSB +: 4];

  // PC arithmetic wraps at 2^ADDR_W; branch offsets are relative to the branch's own PC.
  assign pc_inc   = pc + ADDR_W'(1);
  assign pc_br    = pc + ADDR_W'(sext8(ir[7:0]));
  // Size cast truncates or zero-extends rn to the address width.
  assign mem_addr = ADDR_W'(opa);

  simple_regfile_p #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .clear_n (resetn),
    .ra_idx  (imem_rdata[RN_LSB +: 4]),
    .ra_dat  (ra_dat),
    .rb_idx  (rb_idx),
    .rb_dat  (rb_dat),
    .wr_en   (wr_en),
    .wr_idx  (ir[RD_LSB +: 4]),
    .wr_dat  (wr_dat)
  );

  // Commit decode: register write data/enable and the retire pulse; reset suppresses both.
  always_comb begin
    wr_en  = 1'b0;
    wr_dat = '0;
    retire = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_NOP, OP_BEQZ, OP_JMP, OP_HALT: retire = 1'b1;
        OP_ADD: begin wr_en = 1'b1; wr_dat = opa + opb;                   retire = 1'b1; end
        OP_SUB: begin wr_en = 1'b1; wr_dat = opa - opb;                   retire = 1'b1; end
        OP_LDI: begin wr_en = 1'b1; wr_dat = DATA_W'(zext8(ir[7:0]));     retire = 1'b1; end
        default: ;
      endcase
    end else if (state == S_MEM && dmem_ack) begin
      wr_en  = !dmem_we;
      wr_dat = dmem_rdata;
      retire = 1'b1;
    end
    if (!resetn) begin
      wr_en  = 1'b0;
      retire = 1'b0;
    end
  end

  // Control FSM with registered memory-interface and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      opa        <= '0;
      opb        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_rdata;
          opa   <= ra_dat;
          opb   <= rb_dat;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_LDI: begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
            OP_BEQZ: begin
              pc    <= (opb == '0) ? pc_br : pc_inc;
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc    <= pc_br;
              state <= S_FETCH;
            end
            OP_LD, OP_ST: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_ST);
              dmem_addr  <= mem_addr;
              dmem_wdata <= (op == OP_ST) ? opb : '0;
              state      <= S_MEM;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= pc_inc;
            state    <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu_mc.sv
// Directed bench for simple_cpu_mc: programs in a local instruction ROM,
// a data memory with programmable ack delay, and a second 16-bit-wide core.
module tb_simple_cpu_mc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  pc;
  logic        retire, halted, illegal;

  logic        resetn16;
  logic [7:0]  imem16_addr;
  logic [15:0] imem16_rdata;
  logic        dmem16_req, dmem16_we;
  logic [7:0]  dmem16_addr, pc16;
  logic [15:0] dmem16_wdata;
  logic        retire16, halted16, illegal16;

  logic [15:0] imem   [256];
  logic [15:0] imem16 [256];
  logic [7:0]  dmem   [256];

  int          ack_delay;
  logic        ack_force;
  int          mem_cnt;
  int          st_cnt;
  logic [7:0]  st_addr, st_data;

  int checks = 0;
  int fails  = 0;

  // Per-run statistics filled by run_prog.
  int         n_cyc, n_ret, n_req, n_we, n_bad, n_ack_ret;
  logic [7:0] req_addr, req_wdata;
  logic [7:0] ret_pc [8];

  always #5 clk = ~clk;

  simple_cpu_mc #(.DATA_W(8), .ADDR_W(8), .NREGS(16)) dut (
    .clk(clk), .resetn(resetn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .pc(pc), .retire(retire),
    .halted(halted), .illegal(illegal)
  );

  simple_cpu_mc #(.DATA_W(16), .ADDR_W(8), .NREGS(16)) dut16 (
    .clk(clk), .resetn(resetn16), .imem_addr(imem16_addr), .imem_rdata(imem16_rdata),
    .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
    .dmem_rdata(16'h0000), .dmem_ack(1'b0), .pc(pc16), .retire(retire16),
    .halted(halted16), .illegal(illegal16)
  );

  // Synchronous instruction ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    imem_rdata   <= imem[imem_addr];
    imem16_rdata <= imem16[imem16_addr];
  end

  // Data memory: combinational read, ack after ack_delay MEM cycles, store capture.
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = ack_force || (dmem_req && (mem_cnt == ack_delay - 1));

  always @(posedge clk) begin
    if (!resetn || !dmem_req || dmem_ack) mem_cnt <= 0;
    else                                  mem_cnt <= mem_cnt + 1;
    if (resetn && dmem_req && dmem_ack && dmem_we) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= dmem_addr;
      st_data <= dmem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  // Runs the main core until halted (bounded), recording retires and request behaviour.
  task automatic run_prog(input int budget);
    n_cyc = 0; n_ret = 0; n_req = 0; n_we = 0; n_bad = 0; n_ack_ret = 0;
    while (!halted && n_cyc < budget) begin
      if (retire) begin
        if (n_ret < 8) ret_pc[n_ret] = pc;
        n_ret++;
        if (dmem_req) n_ack_ret++;
      end
      if (dmem_req) begin
        if (n_req == 0) begin
          req_addr  = dmem_addr;
          req_wdata = dmem_wdata;
        end else if (dmem_addr !== req_addr || dmem_wdata !== req_wdata) begin
          n_bad++;
        end
        n_req++;
        if (dmem_we) n_we++;
      end
      tick();
      n_cyc++;
    end
    checks++;
    if (!halted) begin fails++; $display("FAIL run_timeout: halted=%b after %0d cycles, want 1", halted, n_cyc); end
  endtask

  task automatic load_arith();
    clear_imem();
    imem[0] = 16'h3105;  // LDI r1,05
    imem[1] = 16'h3203;  // LDI r2,03
    imem[2] = 16'h2312;  // SUB r3,r1,r2
    imem[3] = 16'h34FF;  // LDI r4,FF
    imem[4] = 16'h1444;  // ADD r4,r4,r4
    imem[5] = 16'hF000;  // HALT
  endtask

  task automatic test_arith();
    load_arith();
    do_reset(2);
    checks++; if (pc !== 8'h00 || halted !== 1'b0 || retire !== 1'b0 || dmem_req !== 1'b0)
      begin fails++; $display("FAIL reset_state: pc=%h halted=%b retire=%b req=%b, want 00 0 0 0", pc, halted, retire, dmem_req); end
    checks++; if (dmem_addr !== 8'h00 || dmem_wdata !== 8'h00 || dmem_we !== 1'b0 || illegal !== 1'b0)
      begin fails++; $display("FAIL reset_dmem: addr=%h wdata=%h we=%b illegal=%b, want 00 00 0 0", dmem_addr, dmem_wdata, dmem_we, illegal); end
    run_prog(40);
    checks++; if (n_cyc !== 18) begin fails++; $display("FAIL arith_cycles: %0d, want 18", n_cyc); end
    checks++; if (n_ret !== 6) begin fails++; $display("FAIL arith_retires: %0d, want 6", n_ret); end
    checks++; if (dut.u_rf.regs[3] !== 8'h02) begin fails++; $display("FAIL arith_sub: r3=%h, want 02", dut.u_rf.regs[3]); end
    checks++; if (dut.u_rf.regs[4] !== 8'hFE) begin fails++; $display("FAIL arith_add_wrap: r4=%h, want FE", dut.u_rf.regs[4]); end
    checks++; if (dut.u_rf.regs[1] !== 8'h05 || dut.u_rf.regs[2] !== 8'h03)
      begin fails++; $display("FAIL arith_ldi: r1=%h r2=%h, want 05 03", dut.u_rf.regs[1], dut.u_rf.regs[2]); end
    checks++; if (pc !== 8'h05 || illegal !== 1'b0) begin fails++; $display("FAIL arith_halt_pc: pc=%h illegal=%b, want 05 0", pc, illegal); end
    repeat (4) tick();
    checks++; if (pc !== 8'h05 || retire !== 1'b0 || dmem_req !== 1'b0)
      begin fails++; $display("FAIL halt_frozen: pc=%h retire=%b req=%b, want 05 0 0", pc, retire, dmem_req); end
  endtask

  task automatic test_reset();
    int nz;
    load_arith();
    do_reset(2);
    repeat (7) tick();
    do_reset(3);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.u_rf.regs[i] !== 8'h00) nz++;
    checks++; if (nz !== 0) begin fails++; $display("FAIL reset_regs: %0d nonzero regs, want 0", nz); end
    checks++; if (pc !== 8'h00 || dmem_req !== 1'b0 || halted !== 1'b0)
      begin fails++; $display("FAIL reset_midrun: pc=%h req=%b halted=%b, want 00 0 0", pc, dmem_req, halted); end
  endtask

  task automatic test_load_wait();
    clear_imem();
    imem[0] = 16'h3105;  // LDI r1,05
    imem[1] = 16'h4510;  // LD r5,[r1]
    dmem[5] = 8'hA5;
    ack_delay = 3;
    do_reset(2);
    run_prog(40);
    checks++; if (dut.u_rf.regs[5] !== 8'hA5) begin fails++; $display("FAIL ld_data: r5=%h, want A5", dut.u_rf.regs[5]); end
    checks++; if (n_req !== 3 || n_we !== 0) begin fails++; $display("FAIL ld_req_cycles: req=%0d we=%0d, want 3 0", n_req, n_we); end
    checks++; if (req_addr !== 8'h05 || n_bad !== 0) begin fails++; $display("FAIL ld_addr_hold: addr=%h unstable=%0d, want 05 0", req_addr, n_bad); end
    checks++; if (n_ack_ret !== 1 || n_ret !== 3) begin fails++; $display("FAIL ld_retire: in_ack=%0d total=%0d, want 1 3", n_ack_ret, n_ret); end
    checks++; if (n_cyc !== 12) begin fails++; $display("FAIL ld_cycles: %0d, want 12 (3+6+3)", n_cyc); end
  endtask

  task automatic test_store();
    int st0;
    clear_imem();
    imem[0] = 16'h3105;  // LDI r1,05
    imem[1] = 16'h3203;  // LDI r2,03
    imem[2] = 16'h5120;  // ST [r2],r1
    ack_delay = 1;
    st0 = st_cnt;
    do_reset(2);
    run_prog(40);
    checks++; if (n_req !== 1 || n_we !== 1) begin fails++; $display("FAIL st_req_cycles: req=%0d we=%0d, want 1 1", n_req, n_we); end
    checks++; if (req_addr !== 8'h03 || req_wdata !== 8'h05) begin fails++; $display("FAIL st_bus: addr=%h wdata=%h, want 03 05", req_addr, req_wdata); end
    checks++; if (st_cnt - st0 !== 1 || st_addr !== 8'h03 || st_data !== 8'h05)
      begin fails++; $display("FAIL st_write: n=%0d addr=%h data=%h, want 1 03 05", st_cnt - st0, st_addr, st_data); end
    checks++; if (n_cyc !== 13 || n_ack_ret !== 1) begin fails++; $display("FAIL st_cycles: %0d ack_ret=%0d, want 13 1", n_cyc, n_ack_ret); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = 16'h3107;  // LDI r1,07
    imem[1] = 16'h7004;  // JMP +4   -> 05
    imem[5] = 16'h60FE;  // BEQZ r0,-2 taken -> 03
    imem[3] = 16'h61FE;  // BEQZ r1,-2 not taken -> 04
    imem[4] = 16'hF000;  // HALT
    do_reset(2);
    run_prog(60);
    checks++; if (n_ret !== 5) begin fails++; $display("FAIL br_retires: %0d, want 5", n_ret); end
    checks++; if (ret_pc[2] !== 8'h05 || ret_pc[3] !== 8'h03 || ret_pc[4] !== 8'h04)
      begin fails++; $display("FAIL br_trace: %h %h %h, want 05 03 04", ret_pc[2], ret_pc[3], ret_pc[4]); end
    clear_imem();
    imem[0]   = 16'h70FF;  // JMP -1 -> FF
    imem[255] = 16'h7002;  // JMP +2 -> 01 (wraps)
    imem[1]   = 16'hF000;
    do_reset(2);
    run_prog(40);
    checks++; if (ret_pc[1] !== 8'hFF || pc !== 8'h01 || n_ret !== 3)
      begin fails++; $display("FAIL jmp_wrap: pc1=%h pc_end=%h retires=%0d, want FF 01 3", ret_pc[1], pc, n_ret); end
  endtask

  task automatic test_trap();
    clear_imem();
    imem[0] = 16'h3105;  // LDI r1,05
    imem[1] = 16'h3203;  // LDI r2,03
    imem[2] = 16'h0000;  // NOP
    imem[3] = 16'h0000;  // NOP
    imem[4] = 16'hA123;  // undefined opcode A, rd=r1
    do_reset(2);
    run_prog(40);
    checks++; if (illegal !== 1'b1 || halted !== 1'b1 || pc !== 8'h04)
      begin fails++; $display("FAIL trap_state: illegal=%b halted=%b pc=%h, want 1 1 04", illegal, halted, pc); end
    checks++; if (n_ret !== 4 || dut.u_rf.regs[1] !== 8'h05)
      begin fails++; $display("FAIL trap_side_effects: retires=%0d r1=%h, want 4 05", n_ret, dut.u_rf.regs[1]); end
  endtask

  task automatic test_reset_in_mem();
    clear_imem();
    imem[0] = 16'h3509;  // LDI r5,09
    imem[1] = 16'h4510;  // LD r5,[r1] (r1=0)
    dmem[0] = 8'h3C;
    ack_delay = 50;
    ack_force = 1'b0;
    do_reset(2);
    repeat (7) tick();
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL mem_wait_req: req=%b, want 1", dmem_req); end
    ack_force = 1'b1;
    resetn    = 1'b0;
    #1;
    checks++; if (retire !== 1'b0) begin fails++; $display("FAIL reset_ack_retire: retire=%b, want 0", retire); end
    tick();
    checks++; if (dmem_req !== 1'b0 || pc !== 8'h00 || dut.u_rf.regs[5] !== 8'h00)
      begin fails++; $display("FAIL reset_over_ack: req=%b pc=%h r5=%h, want 0 00 00", dmem_req, pc, dut.u_rf.regs[5]); end
    ack_force = 1'b0;
    resetn    = 1'b1;
  endtask

  task automatic test_wide();
    int cyc, rets;
    for (int i = 0; i < 256; i++) imem16[i] = 16'hF000;
    imem16[0] = 16'h3105;
    imem16[1] = 16'h3203;
    imem16[2] = 16'h2312;
    imem16[3] = 16'h34FF;
    imem16[4] = 16'h1444;
    resetn16 = 1'b0;
    repeat (2) tick();
    resetn16 = 1'b1;
    cyc = 0; rets = 0;
    while (!halted16 && cyc < 40) begin
      if (retire16) rets++;
      tick();
      cyc++;
    end
    checks++; if (dut16.u_rf.regs[4] !== 16'h01FE) begin fails++; $display("FAIL wide_add: r4=%h, want 01FE", dut16.u_rf.regs[4]); end
    checks++; if (dut16.u_rf.regs[3] !== 16'h0002 || cyc !== 18 || rets !== 6)
      begin fails++; $display("FAIL wide_run: r3=%h cycles=%0d retires=%0d, want 0002 18 6", dut16.u_rf.regs[3], cyc, rets); end
  endtask

  initial begin
    resetn    = 1'b0;
    resetn16  = 1'b0;
    ack_delay = 1;
    ack_force = 1'b0;
    st_cnt    = 0;
    st_addr   = 8'h00;
    st_data   = 8'h00;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    clear_imem();
    for (int i = 0; i < 256; i++) imem16[i] = 16'hF000;
    test_arith();
    test_reset();
    test_load_wait();
    test_store();
    test_branch();
    test_trap();
    test_reset_in_mem();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
